// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared opcode, FSM state and flag index definitions for the RPN datapath
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_MUL = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALC    = 2'd1,
    ST_MUL_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/rpn_seq_mul.sv
// rtl/rpn_seq_mul.sv - shift-add multiplier, one partial product per cycle for WIDTH cycles
// product carries the running sum including the current step, so it is final while done is high.
module rpn_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign product = mplier[0] ? acc + mcand : acc;
  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rpn_datapath.sv
// rtl/rpn_datapath.sv - RPN calculator datapath: operand/opcode registers, ALU, control FSM
// Define RPN_MUL_EN to build the sequential multiplier for opcode MUL; otherwise MUL is invalid.
module rpn_datapath
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_Data,
  input  logic             in_LoadOpA,
  input  logic             in_LoadOpB,
  input  logic             in_LoadOpCode,
  input  logic             in_updateRes,
  input  logic             in_ToDisplaySel,
  output logic [WIDTH-1:0] out_Result,
  output logic [WIDTH-1:0] out_Display,
  output logic             out_Busy,
  output logic             out_ResValid,
  output logic [3:0]       out_Flags,
  output logic             out_Invalid
);
  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] CALC    = ST_CALC;
  localparam logic [1:0] MUL_RUN = ST_MUL_RUN;
  localparam logic [1:0] DONE    = ST_DONE;

  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       opcode;
  logic [1:0]       state;
  logic             load_ab, start_req;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_inv, alu_is_mul;

  assign load_ab     = in_LoadOpA | in_LoadOpB;
  assign start_req   = in_LoadOpCode | in_updateRes;
  assign out_Busy    = (state == CALC) || (state == MUL_RUN);
  assign out_ResValid = (state == DONE);
  assign out_Display = in_ToDisplaySel ? out_Result : in_Data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      opcode <= '0;
    end else begin
      if (in_LoadOpA)    op_a   <= in_Data;
      if (in_LoadOpB)    op_b   <= in_Data;
      if (in_LoadOpCode) opcode <= in_Data[2:0];
    end
  end

  always_comb begin
    sum        = '0;
    alu_res    = '0;
    alu_flags  = '0;
    alu_inv    = 1'b0;
    alu_is_mul = 1'b0;
    case (opcode)
      OP_ADD: begin
        sum               = {1'b0, op_a} + {1'b0, op_b};
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res           = op_a - op_b;
        alu_flags[FLAG_C] = (op_a < op_b);
        alu_flags[FLAG_V] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_OR:  alu_res = op_a | op_b;
      OP_AND: alu_res = op_a & op_b;
`ifdef RPN_MUL_EN
      OP_MUL: alu_is_mul = 1'b1;
`endif
      default: alu_inv = 1'b1;
    endcase
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

`ifdef RPN_MUL_EN
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         mul_flags;

  // Reissuing start on any CALC cycle reloads the multiplier, which is also how restarts abort it
  assign mul_start = (state == CALC) && alu_is_mul;
  assign mul_flags = {mul_product[WIDTH-1], (mul_product[WIDTH-1:0] == '0), 1'b0,
                      |mul_product[2*WIDTH-1:WIDTH]};

  rpn_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Operand loads beat starts; a start beats normal sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_Result  <= '0;
      out_Flags   <= '0;
      out_Invalid <= 1'b0;
    end else if (load_ab) begin
      state <= IDLE;
    end else if (start_req) begin
      state <= CALC;
    end else begin
      case (state)
        CALC: begin
          if (alu_is_mul) begin
            state <= MUL_RUN;
          end else begin
            state       <= DONE;
            out_Result  <= alu_res;
            out_Flags   <= alu_flags;
            out_Invalid <= alu_inv;
          end
        end
`ifdef RPN_MUL_EN
        MUL_RUN: begin
          if (mul_busy && mul_done) begin
            state       <= DONE;
            out_Result  <= mul_product[WIDTH-1:0];
            out_Flags   <= mul_flags;
            out_Invalid <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
